// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control FSM for the RV32I core.
// Owns the architectural PC and instruction register, fetches through a
// request/valid handshake, strobes the execute stage, sequences optional
// data-memory access and writeback, counts retired instructions and halts
// on illegal instruction, misaligned next PC or memory timeout.

module exec_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,

    output logic [31:0] pc,
    output logic [31:0] ir,

    input  logic        dec_illegal,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_reg_we,

    input  logic [31:0] pc_next_in,
    output logic        ex_en,

    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,

    output logic        rf_we,
    output logic [31:0] instret,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [2:0]  state
);

    // Nine bits hold every count up to the largest legal timeout of 256.
    localparam int         CNT_W    = 9;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'd0,
        CAUSE_ILLEGAL   = 2'd1,
        CAUSE_MISALIGN  = 2'd2,
        CAUSE_TIMEOUT   = 2'd3
    } cause_t;

    state_t           state_q;
    cause_t           cause_q;
    logic [31:0]      pc_q;
    logic [31:0]      ir_q;
    logic [31:0]      instret_q;
    logic [CNT_W-1:0] wait_cnt;

    // The execute stage's next PC must be word aligned to retire.
    logic wb_ok;
    assign wb_ok = (pc_next_in[1:0] == 2'b00);

    // Outstanding request has reached its last permitted cycle.
    logic wait_expired;
    assign wait_expired = (wait_cnt == CNT_LAST);

    // Single sequencing process: state, architectural registers, wait counter.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cause_q   <= CAUSE_NONE;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            instret_q <= 32'h0;
            wait_cnt  <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir_q     <= imem_rdata;
                        wait_cnt <= '0;
                        state_q  <= S_DECODE;
                    end else if (wait_expired) begin
                        cause_q  <= CAUSE_TIMEOUT;
                        state_q  <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_DECODE: begin
                    if (dec_illegal) begin
                        cause_q <= CAUSE_ILLEGAL;
                        state_q <= S_HALT;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    state_q <= (dec_is_load || dec_is_store) ? S_MEM : S_WB;
                end

                S_MEM: begin
                    if (dmem_ready) begin
                        wait_cnt <= '0;
                        state_q  <= S_WB;
                    end else if (wait_expired) begin
                        cause_q  <= CAUSE_TIMEOUT;
                        state_q  <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_WB: begin
                    if (!wb_ok) begin
                        cause_q <= CAUSE_MISALIGN;
                        state_q <= S_HALT;
                    end else begin
                        pc_q      <= pc_next_in;
                        instret_q <= instret_q + 32'd1;
                        state_q   <= S_FETCH;
                    end
                end

                S_HALT: begin
                    state_q <= S_HALT;
                end

                // NOTE: the unused encodings 6 and 7 are trapped explicitly so
                // a corrupted state register lands in HALT instead of wandering.
                default: begin
                    cause_q <= CAUSE_NONE;
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    // Strobes and requests are pure decodes of the registered state, so they
    // follow an asynchronous reset in the same instant.
    // NOTE: continuous assigns with a full expression on every path cannot
    // infer a latch, unlike an incomplete always_comb.
    assign imem_req   = (state_q == S_FETCH);
    assign ex_en      = (state_q == S_EXEC);
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = (state_q == S_MEM) && dec_is_store;
    assign rf_we      = (state_q == S_WB) && dec_reg_we && wb_ok;
    assign halted     = (state_q == S_HALT);

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign instret    = instret_q;
    assign halt_cause = cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer. The bench plays the instruction
// memory, decoder, execute stage and data memory. A per-instruction model
// derives the expected cycle-by-cycle outputs from the instruction's
// attributes (fetch wait, memory wait, flags, next PC).

module tb_exec_sequencer;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          MEM_TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        dec_illegal;
    logic        dec_is_load;
    logic        dec_is_store;
    logic        dec_reg_we;
    logic [31:0] pc_next_in;
    logic        ex_en;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        rf_we;
    logic [31:0] instret;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [2:0]  state;

    exec_sequencer #(
        .RESET_PC    (RESET_PC),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .ir           (ir),
        .dec_illegal  (dec_illegal),
        .dec_is_load  (dec_is_load),
        .dec_is_store (dec_is_store),
        .dec_reg_we   (dec_reg_we),
        .pc_next_in   (pc_next_in),
        .ex_en        (ex_en),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .rf_we        (rf_we),
        .instret      (instret),
        .halted       (halted),
        .halt_cause   (halt_cause),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the architectural state.
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_instret;
    logic [1:0]  m_cause;

    int n_cmp;
    int n_err;

    bit          stopped;
    logic [31:0] word;
    logic [31:0] nxt;
    logic [31:0] tmp;
    int          r;
    bit          r_ld;
    bit          r_st;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Random activity on response inputs in cycles where they must be ignored.
    task automatic drive_noise();
        imem_valid = 1'($urandom_range(0, 1));
        dmem_ready = 1'($urandom_range(0, 1));
    endtask

    // Inputs are already driven; check at the falling edge, then advance.
    task automatic check_cycle(input string tag, input bit e_imem, input bit e_ex,
                               input bit e_dmem, input bit e_we, input bit e_rf,
                               input logic [2:0] e_state);
        @(negedge clk);
        check({tag, ".state"},     state,      e_state);
        check({tag, ".imem_req"},  imem_req,   e_imem);
        check({tag, ".ex_en"},     ex_en,      e_ex);
        check({tag, ".dmem_req"},  dmem_req,   e_dmem);
        check({tag, ".dmem_we"},   dmem_we,    e_we);
        check({tag, ".rf_we"},     rf_we,      e_rf);
        check({tag, ".pc"},        pc,         m_pc);
        check({tag, ".imem_addr"}, imem_addr,  m_pc);
        check({tag, ".ir"},        ir,         m_ir);
        check({tag, ".instret"},   instret,    m_instret);
        check({tag, ".halted"},    halted,     1'b0);
        check({tag, ".cause"},     halt_cause, 2'd0);
        @(posedge clk);
        #1;
    endtask

    // One instruction; fw/mw are response wait cycles (>= MEM_TIMEOUT: none).
    task automatic run_instr(input int fw, input int mw, input bit ld, input bit st,
                             input bit rwe, input bit ill, input logic [31:0] w,
                             input logic [31:0] n, output bit stp);
        stp          = 1'b0;
        dec_illegal  = ill;
        dec_is_load  = ld;
        dec_is_store = st;
        dec_reg_we   = rwe;
        imem_rdata   = w;
        pc_next_in   = n;

        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            imem_valid = (i == fw);
            dmem_ready = 1'($urandom_range(0, 1));
            check_cycle("fetch", 1, 0, 0, 0, 0, 3'd0);
            if (i == fw) break;
        end
        if (fw >= MEM_TIMEOUT) begin
            m_cause = 2'd3;
            stp     = 1'b1;
            return;
        end
        m_ir = w;

        drive_noise();
        check_cycle("decode", 0, 0, 0, 0, 0, 3'd1);
        if (ill) begin
            m_cause = 2'd1;
            stp     = 1'b1;
            return;
        end

        drive_noise();
        check_cycle("exec", 0, 1, 0, 0, 0, 3'd2);

        if (ld || st) begin
            for (int j = 0; j < MEM_TIMEOUT; j++) begin
                imem_valid = 1'($urandom_range(0, 1));
                dmem_ready = (j == mw);
                check_cycle("mem", 0, 0, 1, st, 0, 3'd3);
                if (j == mw) break;
            end
            if (mw >= MEM_TIMEOUT) begin
                m_cause = 2'd3;
                stp     = 1'b1;
                return;
            end
        end

        drive_noise();
        check_cycle("wb", 0, 0, 0, 0, rwe && (n[1:0] == 2'b00), 3'd4);
        if (n[1:0] != 2'b00) begin
            m_cause = 2'd2;
            stp     = 1'b1;
        end else begin
            m_pc      = n;
            m_instret = m_instret + 32'd1;
        end
    endtask

    // HALT is absorbing: everything frozen, responses ignored.
    task automatic check_halt(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            drive_noise();
            @(negedge clk);
            check("halt.halted",  halted,     1'b1);
            check("halt.state",   state,      3'd5);
            check("halt.cause",   halt_cause, m_cause);
            check("halt.pc",      pc,         m_pc);
            check("halt.ir",      ir,         m_ir);
            check("halt.instret", instret,    m_instret);
            check("halt.strobes", {imem_req, ex_en, dmem_req, dmem_we, rf_we}, 5'b0);
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; releases reset at posedge+1 so the next cycle is
    // the first FETCH cycle.
    task automatic do_reset();
        rst        = 1'b1;
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        #2;
        check("rst.async_state", state, 3'd0);
        check("rst.async_strobes", {ex_en, dmem_req, dmem_we, rf_we, halted}, 5'b0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        m_pc      = RESET_PC;
        m_ir      = 32'h0;
        m_instret = 32'h0;
        m_cause   = 2'd0;
        check("rst.pc",      pc,         RESET_PC);
        check("rst.ir",      ir,         32'h0);
        check("rst.instret", instret,    32'h0);
        check("rst.cause",   halt_cause, 2'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        imem_valid   = 1'b0;
        imem_rdata   = 32'h0;
        dec_illegal  = 1'b0;
        dec_is_load  = 1'b0;
        dec_is_store = 1'b0;
        dec_reg_we   = 1'b0;
        pc_next_in   = 32'h0;
        dmem_ready   = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Three 1-cycle-fetch ALU instructions: pc 0 -> 4 -> 8 -> C.
        for (int i = 0; i < 3; i++) begin
            run_instr(0, 0, 0, 0, 1, 0, 32'h0000_0013 + 32'(i), m_pc + 32'd4, stopped);
        end
        check("alu3.pc",      pc,      32'h0000_000C);
        check("alu3.instret", instret, 32'd3);

        // Store with data memory ready after 3 wait cycles.
        run_instr(0, 3, 0, 1, 0, 0, 32'h0000_2023, m_pc + 32'd4, stopped);
        check("store.instret", instret, 32'd4);

        // Load with slow fetch and slow data.
        run_instr(2, 1, 1, 0, 1, 0, 32'h0000_2003, m_pc + 32'd4, stopped);

        // Illegal instruction halts from DECODE.
        run_instr(0, 0, 0, 0, 1, 1, 32'hFFFF_FFFF, m_pc + 32'd4, stopped);
        check("illegal.stopped", 32'(stopped), 32'd1);
        check_halt(6);

        // Branch to a misaligned target halts from WB.
        do_reset();
        run_instr(0, 0, 0, 0, 1, 0, 32'h0000_0013, 32'h0000_0040, stopped);
        run_instr(0, 0, 0, 0, 1, 0, 32'h0000_0063, 32'h0000_0102, stopped);
        check_halt(3);

        // Fetch timeout after exactly MEM_TIMEOUT cycles.
        do_reset();
        run_instr(MEM_TIMEOUT, 0, 0, 0, 1, 0, 32'h0000_0013, 32'h4, stopped);
        check_halt(3);

        // Response in the last permitted cycle is accepted.
        do_reset();
        run_instr(MEM_TIMEOUT - 1, 0, 0, 0, 1, 0, 32'h0000_0013, 32'h4, stopped);
        run_instr(0, MEM_TIMEOUT - 1, 1, 0, 1, 0, 32'h0000_2003, 32'h8, stopped);
        check("lastcycle.instret", instret, 32'd2);

        // Data-memory timeout.
        run_instr(0, MEM_TIMEOUT, 0, 1, 0, 0, 32'h0000_2023, 32'hC, stopped);
        check_halt(3);

        // Reset asserted mid-MEM between clock edges.
        do_reset();
        dec_illegal  = 1'b0;
        dec_is_load  = 1'b1;
        dec_is_store = 1'b0;
        dec_reg_we   = 1'b1;
        imem_rdata   = 32'h0000_2003;
        pc_next_in   = 32'h4;
        imem_valid   = 1'b1;
        check_cycle("midrst.fetch", 1, 0, 0, 0, 0, 3'd0);
        m_ir = 32'h0000_2003;
        imem_valid = 1'b0;
        check_cycle("midrst.decode", 0, 0, 0, 0, 0, 3'd1);
        check_cycle("midrst.exec", 0, 1, 0, 0, 0, 3'd2);
        dmem_ready = 1'b0;
        @(negedge clk);
        check("midrst.dmem_req_before", dmem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst.dmem_req_after", dmem_req, 1'b0);
        check("midrst.state", state, 3'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        m_pc      = RESET_PC;
        m_ir      = 32'h0;
        m_instret = 32'h0;
        m_cause   = 2'd0;
        check("midrst.pc",      pc,      RESET_PC);
        check("midrst.instret", instret, 32'h0);
        check("midrst.ir",      ir,      32'h0);

        // Randomized instruction stream.
        for (int t = 0; t < 300; t++) begin
            tmp  = $urandom();
            word = $urandom();
            r    = int'($urandom_range(0, 15));
            if (r == 0)
                nxt = {tmp[31:2], 2'($urandom_range(1, 3))};
            else if (r < 4)
                nxt = {tmp[31:2], 2'b00};
            else
                nxt = m_pc + 32'd4;
            r_ld = ($urandom_range(0, 3) == 0);
            r_st = !r_ld && ($urandom_range(0, 3) == 0);
            run_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      r_ld, r_st, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 19) == 0), word, nxt, stopped);
            if (stopped) begin
                check_halt(2);
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
